lfsr_counter_gen: RTL and testbench
===================================

Name: lfsr_counter_gen

Overview:
- Parametrised shift-register counter. Generalises the fixed 4-bit XOR-feedback D-flip-flop chain to any width, a programmable tap mask, and selectable LFSR, ring, Johnson or hold modes.
- Adds synchronous seed load, enable, all-zero lockup detection with optional auto-recovery, and hardware period measurement (wrap pulse and period register).
- Used as a pattern/sequence source and self-checking counter in counter test benches.

Parameters:
- WIDTH, 4, state width in bits (>=2).
- TAPS, 4'b0011, feedback XOR mask over Q bits; the feedback bit enters the MSB.
- SEED, 4'b0100, reset and recovery state; must be nonzero.
- AUTO_RECOVER, 1, 1 = an LFSR-mode step from all-zero loads SEED instead of shifting.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  step enable.
- MODE  in  2  00 LFSR, 01 ring, 10 Johnson, 11 hold.
- LOAD  in  1  synchronous load of LOAD_VAL.
- LOAD_VAL  in  WIDTH  value to load.
- Q  out  WIDTH  current state.
- LOCKUP  out  1  high when MODE==00 and Q==0 (combinational from registers/inputs).
- WRAP  out  1  one-cycle registered pulse: Q has just returned to the reference state.
- STEP_CNT  out  WIDTH+1  steps since the last reset, load, recovery or wrap.
- PERIOD  out  WIDTH+1  length of the last completed cycle.

Behaviour:
- Reset (async, RST=1): Q=SEED, REF=SEED, STEP_CNT=0, PERIOD=0, WRAP=0. All registers hold while RST is high. Reset mid-sequence discards all progress.
- Edge priority: RST > LOAD > recovery > step > idle.
- LOAD=1 (EN ignored):
  - Q=LOAD_VAL, REF=LOAD_VAL, STEP_CNT=0, WRAP=0.
  - PERIOD is unchanged.
- Step: occurs when EN=1 and MODE!=11. Let fb = XOR-reduce(Q & TAPS). Next state N is:
  - LFSR: {fb, Q[WIDTH-1:1]}
  - ring: {Q[0], Q[WIDTH-1:1]}
  - Johnson: {~Q[0], Q[WIDTH-1:1]}
- Recovery: when AUTO_RECOVER=1, MODE=00, Q==0 and EN=1, the edge acts as a load of SEED. Q=SEED, REF=SEED, STEP_CNT=0, WRAP=0.
- On a step, Q<=N. Then:
  - If N==REF: WRAP<=1, PERIOD<=STEP_CNT+1, STEP_CNT<=0.
  - Otherwise: WRAP<=0, STEP_CNT<=STEP_CNT+1, saturating at all-ones (no wrap-around of the counter).
- Idle (EN=0 or MODE=11, no LOAD): Q, STEP_CNT and PERIOD hold; WRAP<=0.
- Latency: Q, WRAP, STEP_CNT and PERIOD all update on the same edge. WRAP is high in exactly the cycle Q first equals REF again.
- Mode change mid-run: takes effect on the next step. REF and STEP_CNT are not cleared, so PERIOD reflects the mixed sequence.
- AUTO_RECOVER=0 with LFSR lockup: Q stays 0, N==REF==0, so WRAP pulses every enabled step and PERIOD=1.
- Non-LFSR modes never assert LOCKUP, even at Q==0.
- Simultaneous LOAD with a would-be wrap: the load wins, and WRAP=0.

Test Plan:
1. Defaults, reset, MODE=00, EN=1 for 15 edges.
   -> Q sequence: 0100, 0010, 1001, 1100, 0110, 1011, 0101, 1010, 1101, 1110, 1111, 0111, 0011, 0001, 1000, 0100.
   -> WRAP=1 only on edge 15; PERIOD=15; STEP_CNT=0.
2. LOAD 0001, MODE=01, EN=1 for 4 edges.
   -> Q: 1000, 0100, 0010, 0001.
   -> WRAP on edge 4; PERIOD=4.
3. LOAD 0000, MODE=10, 8 edges.
   -> Q: 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
   -> WRAP on edge 8; PERIOD=8.
4. LOAD 0000, MODE=00.
   -> LOCKUP=1 the cycle after the load.
   -> Next EN edge: Q=0100, LOCKUP=0, STEP_CNT=0.
   -> With AUTO_RECOVER=0: Q stays 0000, WRAP every edge, PERIOD=1.
5. Scenario 1, toggling EN=0 and MODE=11 for 3 cycles at step 5.
   -> Q and STEP_CNT hold during the pause; PERIOD is still 15 at wrap.
6. Assert RST asynchronously between edges at step 7.
   -> Q=0100, STEP_CNT=0, PERIOD=0, WRAP=0 immediately.
   -> Also: LOAD asserted together with EN on a wrap edge gives Q=LOAD_VAL and WRAP=0.

Source files
------------

// File: rtl/lfsr_counter_gen.sv
// Parametrised shift-register sequence generator (LFSR / ring / Johnson / hold)
// with seed load, lockup detection, auto-recovery and period measurement.
module lfsr_counter_gen #(
  parameter int                WIDTH        = 4,
  parameter logic [WIDTH-1:0]  TAPS         = 4'b0011,
  parameter logic [WIDTH-1:0]  SEED         = 4'b0100,
  parameter int                AUTO_RECOVER = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] Q,
  output logic             LOCKUP,
  output logic             WRAP,
  output logic [WIDTH:0]   STEP_CNT,
  output logic [WIDTH:0]   PERIOD
);

  typedef enum logic [1:0] {
    MODE_LFSR    = 2'b00,
    MODE_RING    = 2'b01,
    MODE_JOHNSON = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  localparam bit RECOVER_EN = (AUTO_RECOVER != 0);

  mode_e            mode;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] ref_r;
  logic [WIDTH:0]   step_cnt_r;
  logic [WIDTH:0]   period_r;
  logic             wrap_r;

  logic [WIDTH-1:0] nxt;
  logic             fb;
  logic             do_step;
  logic             do_recover;
  logic             hits_ref;

  // Counter increments stick at all-ones so an unbounded run never aliases
  // back onto a short period.
  function automatic logic [WIDTH:0] sat_inc(input logic [WIDTH:0] v);
    return (&v) ? v : v + {{WIDTH{1'b0}}, 1'b1};
  endfunction

  assign mode = mode_e'(MODE);

  always_comb begin
    fb  = ^(q_r & TAPS);
    nxt = q_r;
    case (mode)
      MODE_LFSR:    nxt = {fb,     q_r[WIDTH-1:1]};
      MODE_RING:    nxt = {q_r[0], q_r[WIDTH-1:1]};
      MODE_JOHNSON: nxt = {~q_r[0], q_r[WIDTH-1:1]};
      default:      nxt = q_r;
    endcase
  end

  assign do_step    = EN && (mode != MODE_HOLD);
  assign do_recover = RECOVER_EN && EN && (mode == MODE_LFSR) && (q_r == '0);
  assign hits_ref   = (nxt == ref_r);

  // Priority: reset > load > recovery > step > idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_r        <= SEED;
      ref_r      <= SEED;
      step_cnt_r <= '0;
      period_r   <= '0;
      wrap_r     <= 1'b0;
    end else if (LOAD) begin
      q_r        <= LOAD_VAL;
      ref_r      <= LOAD_VAL;
      step_cnt_r <= '0;
      wrap_r     <= 1'b0;
    end else if (do_recover) begin
      q_r        <= SEED;
      ref_r      <= SEED;
      step_cnt_r <= '0;
      wrap_r     <= 1'b0;
    end else if (do_step) begin
      q_r <= nxt;
      if (hits_ref) begin
        wrap_r     <= 1'b1;
        period_r   <= sat_inc(step_cnt_r);
        step_cnt_r <= '0;
      end else begin
        wrap_r     <= 1'b0;
        step_cnt_r <= sat_inc(step_cnt_r);
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign Q        = q_r;
  assign WRAP     = wrap_r;
  assign STEP_CNT = step_cnt_r;
  assign PERIOD   = period_r;
  assign LOCKUP   = (mode == MODE_LFSR) && (q_r == '0);

endmodule

// File: tb/tb_lfsr_counter_gen.sv
// Bench for lfsr_counter_gen: directed vector table, hand-written corner
// sequences and randomized stimulus against an arithmetic reference model.
module tb_lfsr_counter_gen;

  localparam int W       = 4;
  localparam int TAPS_I  = 3;
  localparam int SEED_I  = 4;
  localparam int CNT_MAX = (1 << (W + 1)) - 1;

  logic         CLK;
  logic         RST;
  logic         EN;
  logic [1:0]   MODE;
  logic         LOAD;
  logic [W-1:0] LOAD_VAL;

  logic [W-1:0] Q,        q_nr;
  logic         LOCKUP,   lockup_nr;
  logic         WRAP,     wrap_nr;
  logic [W:0]   STEP_CNT, step_cnt_nr;
  logic [W:0]   PERIOD,   period_nr;

  lfsr_counter_gen #(.WIDTH(W), .TAPS(4'b0011), .SEED(4'b0100), .AUTO_RECOVER(1)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .Q(Q), .LOCKUP(LOCKUP), .WRAP(WRAP), .STEP_CNT(STEP_CNT), .PERIOD(PERIOD)
  );

  lfsr_counter_gen #(.WIDTH(W), .TAPS(4'b0011), .SEED(4'b0100), .AUTO_RECOVER(0)) dut_nr (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .Q(q_nr), .LOCKUP(lockup_nr), .WRAP(wrap_nr), .STEP_CNT(step_cnt_nr), .PERIOD(period_nr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model of the AUTO_RECOVER=1 instance.
  int m_q, m_ref, m_cnt, m_per, m_wrap;

  task automatic model_reset();
    m_q = SEED_I; m_ref = SEED_I; m_cnt = 0; m_per = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input bit ld, input int lv, input bit en, input int md);
    int n, fb;
    fb = $countones(m_q & TAPS_I) % 2;
    case (md)
      0:       n = (m_q >> 1) + fb * (1 << (W - 1));
      1:       n = (m_q >> 1) + (m_q % 2) * (1 << (W - 1));
      2:       n = (m_q >> 1) + (1 - m_q % 2) * (1 << (W - 1));
      default: n = m_q;
    endcase
    if (ld) begin
      m_q = lv; m_ref = lv; m_cnt = 0; m_wrap = 0;
    end else if (en && md == 0 && m_q == 0) begin
      m_q = SEED_I; m_ref = SEED_I; m_cnt = 0; m_wrap = 0;
    end else if (en && md != 3) begin
      m_q = n;
      if (n == m_ref) begin
        m_wrap = 1; m_per = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1; m_cnt = 0;
      end else begin
        m_wrap = 0; m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q"},      int'(Q),        m_q);
    chk({tag, ".wrap"},   int'(WRAP),     m_wrap);
    chk({tag, ".cnt"},    int'(STEP_CNT), m_cnt);
    chk({tag, ".period"}, int'(PERIOD),   m_per);
    chk({tag, ".lockup"}, int'(LOCKUP),   int'(MODE == 2'b00 && m_q == 0));
  endtask

  task automatic drive(input bit ld, input logic [W-1:0] lv, input bit en, input logic [1:0] md);
    LOAD = ld; LOAD_VAL = lv; EN = en; MODE = md;
    @(posedge CLK);
    model_edge(ld, int'(lv), en, int'(md));
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    #2;
    RST = 1'b0;
  endtask

  typedef struct {
    bit           ld;
    logic [W-1:0] lv;
    bit           en;
    logic [1:0]   md;
    logic [W-1:0] q;
    bit           wrap;
    int           cnt;
    int           per;
    bit           lock;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit ld, input logic [W-1:0] lv, input bit en, input logic [1:0] md,
                     input logic [W-1:0] q, input bit wrap, input int cnt, input int per,
                     input bit lock);
    vec_t v;
    v.ld = ld; v.lv = lv; v.en = en; v.md = md;
    v.q = q; v.wrap = wrap; v.cnt = cnt; v.per = per; v.lock = lock;
    tbl.push_back(v);
  endtask

  logic [W-1:0] s_lfsr [15] = '{4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011,
                                4'b0101, 4'b1010, 4'b1101, 4'b1110, 4'b1111,
                                4'b0111, 4'b0011, 4'b0001, 4'b1000, 4'b0100};
  logic [W-1:0] s_ring [4]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [W-1:0] s_john [8]  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                4'b0111, 4'b0011, 4'b0001, 4'b0000};

  initial begin
    RST = 1'b1; EN = 1'b0; MODE = 2'b00; LOAD = 1'b0; LOAD_VAL = '0;
    model_reset();

    // Directed vector table: full LFSR cycle, ring, Johnson, lockup recovery.
    for (int i = 0; i < 15; i++)
      add(0, 4'b0000, 1, 2'b00, s_lfsr[i], i == 14, (i == 14) ? 0 : i + 1, (i == 14) ? 15 : 0, 0);
    add(1, 4'b0001, 1, 2'b01, 4'b0001, 0, 0, 15, 0);
    for (int i = 0; i < 4; i++)
      add(0, 4'b0000, 1, 2'b01, s_ring[i], i == 3, (i == 3) ? 0 : i + 1, (i == 3) ? 4 : 15, 0);
    add(1, 4'b0000, 1, 2'b10, 4'b0000, 0, 0, 4, 0);
    for (int i = 0; i < 8; i++)
      add(0, 4'b0000, 1, 2'b10, s_john[i], i == 7, (i == 7) ? 0 : i + 1, (i == 7) ? 8 : 4, 0);
    add(1, 4'b0000, 0, 2'b00, 4'b0000, 0, 0, 8, 1);
    add(0, 4'b0000, 1, 2'b00, 4'b0100, 0, 0, 8, 0);
    add(0, 4'b0000, 1, 2'b00, 4'b0010, 0, 1, 8, 0);

    #1;
    chk("reset.q",      int'(Q),        SEED_I);
    chk("reset.cnt",    int'(STEP_CNT), 0);
    chk("reset.period", int'(PERIOD),   0);
    chk("reset.wrap",   int'(WRAP),     0);
    chk("reset.lockup", int'(LOCKUP),   0);
    @(negedge CLK);
    RST = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].md);
      chk($sformatf("tbl%0d.q", i),      int'(Q),        int'(tbl[i].q));
      chk($sformatf("tbl%0d.wrap", i),   int'(WRAP),     int'(tbl[i].wrap));
      chk($sformatf("tbl%0d.cnt", i),    int'(STEP_CNT), tbl[i].cnt);
      chk($sformatf("tbl%0d.period", i), int'(PERIOD),   tbl[i].per);
      chk($sformatf("tbl%0d.lockup", i), int'(LOCKUP),   int'(tbl[i].lock));
    end

    // No auto-recovery: all-zero state wraps on every enabled step.
    do_reset();
    drive(1, 4'b0000, 1, 2'b00);
    chk("norec.lockup0", int'(lockup_nr), 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b0000, 1, 2'b00);
      chk($sformatf("norec%0d.q", i),      int'(q_nr),        0);
      chk($sformatf("norec%0d.wrap", i),   int'(wrap_nr),     1);
      chk($sformatf("norec%0d.period", i), int'(period_nr),   1);
      chk($sformatf("norec%0d.cnt", i),    int'(step_cnt_nr), 0);
      chk($sformatf("norec%0d.lockup", i), int'(lockup_nr),   1);
    end

    // Pause mid-sequence: EN low and hold mode must freeze state and count.
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 4'b0000, 1, 2'b00);
    chk("pause.pre_q", int'(Q), 4'b1011);
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b0000, i == 1, (i == 0) ? 2'b00 : 2'b11);
      chk($sformatf("pause%0d.q", i),    int'(Q),        4'b1011);
      chk($sformatf("pause%0d.cnt", i),  int'(STEP_CNT), 5);
      chk($sformatf("pause%0d.wrap", i), int'(WRAP),     0);
    end
    for (int i = 0; i < 9; i++) drive(0, 4'b0000, 1, 2'b00);
    chk("pause.cnt14", int'(STEP_CNT), 14);
    chk("pause.nowrap", int'(WRAP), 0);
    drive(0, 4'b0000, 1, 2'b00);
    chk("pause.wrap",   int'(WRAP),   1);
    chk("pause.period", int'(PERIOD), 15);
    chk("pause.q",      int'(Q),      SEED_I);

    // Asynchronous reset between edges discards period and progress.
    for (int i = 0; i < 7; i++) drive(0, 4'b0000, 1, 2'b00);
    chk("areset.pre_q",   int'(Q),        4'b1010);
    chk("areset.pre_cnt", int'(STEP_CNT), 7);
    chk("areset.pre_per", int'(PERIOD),   15);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    chk("areset.q",      int'(Q),        SEED_I);
    chk("areset.cnt",    int'(STEP_CNT), 0);
    chk("areset.period", int'(PERIOD),   0);
    chk("areset.wrap",   int'(WRAP),     0);
    @(posedge CLK);
    #1;
    chk("areset.hold_q", int'(Q), SEED_I);
    @(negedge CLK);
    RST = 1'b0;

    // Load coinciding with a would-be wrap edge.
    do_reset();
    for (int i = 0; i < 14; i++) drive(0, 4'b0000, 1, 2'b00);
    chk("ldwrap.pre_q", int'(Q), 4'b1000);
    drive(1, 4'b1010, 1, 2'b00);
    chk("ldwrap.q",      int'(Q),        4'b1010);
    chk("ldwrap.wrap",   int'(WRAP),     0);
    chk("ldwrap.cnt",    int'(STEP_CNT), 0);
    chk("ldwrap.period", int'(PERIOD),   0);

    // Step counter saturation: ring on 1111 never returns to ref 1110.
    do_reset();
    drive(1, 4'b1110, 1, 2'b00);
    drive(0, 4'b0000, 1, 2'b00);
    chk("sat.q1", int'(Q), 4'b1111);
    for (int i = 0; i < 40; i++) drive(0, 4'b0000, 1, 2'b01);
    chk("sat.cnt",  int'(STEP_CNT), CNT_MAX);
    chk("sat.wrap", int'(WRAP),     0);
    check_model("sat");

    // Randomized stimulus against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit           ld, en;
      logic [W-1:0] lv;
      logic [1:0]   md;
      ld = ($urandom_range(0, 15) == 0);
      lv = W'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      md = 2'($urandom_range(0, 3));
      drive(ld, lv, en, md);
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
